fmul_wb_tracker: RTL and testbench

- Writeback tracker that sits directly downstream of the 3-stage fmul pipeline. fmul has fixed latency and cannot stall.
- Carries each issued multiply's destination register tag through a shift pipe that is cycle-aligned with fmul.
- On arrival, captures the fmul result together with its tag into a small FIFO, then drains to the register file over a valid/ready handshake.
- Applies credit-based issue throttling so a result is never lost, and exports a per-register pending mask for hazard checks.

---
 rtl/fmul_wb_tracker.sv | 162 ++++++++++++++++
 tb/tb_fmul_wb_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_wb_tracker.sv
// fmul_wb_tracker
//   Writeback tracker placed directly downstream of the fixed-latency,
//   non-stalling fmul pipeline. Each accepted multiply's destination tag
//   travels through a shift pipe aligned with fmul. When the tag reaches the
//   end of the pipe, the tag and the fmul result are captured together into a
//   small circular FIFO. The FIFO drains to the register file over valid/ready.
//   Issue is throttled by credits, so a result can never be dropped. A
//   per-register pending mask is exported for hazard checks.
//
// Ports
//   clk          clock
//   reset        synchronous, active-low reset
//   issue_valid  issuer presents operands and issue_rd this cycle
//   issue_rd     destination register tag of the multiply
//   issue_ready  issue accepted when issue_valid && issue_ready
//   fmul_result  fmul output result register
//   wb_valid     FIFO head valid
//   wb_rd        FIFO head tag (0 when empty)
//   wb_data      FIFO head data (0 when empty)
//   wb_ready     register file accepts the head entry
//   pending      bit r set while a multiply targeting r is in flight or queued

module fmul_wb_tracker #(
  parameter int TAG_W = 5,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [TAG_W-1:0]    issue_rd,
  output logic                issue_ready,
  input  logic [31:0]         fmul_result,
  output logic                wb_valid,
  output logic [TAG_W-1:0]    wb_rd,
  output logic [31:0]         wb_data,
  input  logic                wb_ready,
  output logic [2**TAG_W-1:0] pending
);

  localparam int NREG  = 2**TAG_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + LAT + 1);

  logic [LAT-1:0]   pv_q, pv_d;
  logic [TAG_W-1:0] ptag_q [LAT];
  logic [TAG_W-1:0] ptag_d [LAT];

  logic [TAG_W-1:0] mem_tag_q  [DEPTH];
  logic [TAG_W-1:0] mem_tag_d  [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [31:0]      mem_data_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NREG-1:0]  pending_q, pending_d;

  logic [SUM_W-1:0] inflight;
  logic             issue_fire;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Number of valid pipe stages. Every one of them holds a future FIFO push.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + SUM_W'(pv_q[i]);
    end
  end

  // Credit check uses registered state only. A pop in the same cycle is
  // deliberately not credited, which keeps issue_ready off the wb_ready path.
  assign issue_ready = reset
                     && ((SUM_W'(count_q) + inflight) < SUM_W'(DEPTH))
                     && !pending_q[issue_rd];
  assign issue_fire  = issue_valid && issue_ready;

  assign push     = pv_q[LAT-1];
  assign wb_valid = (count_q != '0);
  assign pop      = wb_valid && wb_ready;
  assign wb_rd    = wb_valid ? mem_tag_q[rd_ptr_q]  : '0;
  assign wb_data  = wb_valid ? mem_data_q[rd_ptr_q] : '0;
  assign pending  = pending_q;

  // Tag pipe: stage0 loads on every edge and the pipe never stalls.
  always_comb begin
    pv_d      = '0;
    ptag_d    = ptag_q;
    pv_d[0]   = issue_fire;
    ptag_d[0] = issue_rd;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i]   = pv_q[i-1];
      ptag_d[i] = ptag_q[i-1];
    end
  end

  // FIFO storage and pointers. A push and a pop on the same edge leave the
  // count unchanged.
  always_comb begin
    mem_tag_d  = mem_tag_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_tag_d[wr_ptr_q]  = ptag_q[LAT-1];
      mem_data_d[wr_ptr_q] = fmul_result;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pending mask. The WAW block on issue guarantees that set and clear never
  // hit the same bit on one edge.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (issue_fire) begin
      pending_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pv_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      pv_q      <= pv_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Payload storage needs no reset. Its contents are qualified by the valid
  // bits and the count.
  always_ff @(posedge clk) begin
    ptag_q     <= ptag_d;
    mem_tag_q  <= mem_tag_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: tb/tb_fmul_wb_tracker.sv
// Self-checking bench for fmul_wb_tracker. A small fmul stand-in supplies
// results with the real pipeline timing. A queue-based reference model
// predicts every output each cycle.

module tb_fmul_wb_tracker;

   localparam int TAG_W = 5;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam int NREG  = 32;

   logic             clk;
   logic             reset;
   logic             issue_valid;
   logic [TAG_W-1:0] issue_rd;
   logic             issue_ready;
   logic [31:0]      fmul_result;
   logic             wb_valid;
   logic [TAG_W-1:0] wb_rd;
   logic [31:0]      wb_data;
   logic             wb_ready;
   logic [NREG-1:0]  pending;

   int opA;
   int opB;
   int testCount;
   int failCount;
   int edgeNum;

   typedef struct {
      logic [TAG_W-1:0] rd;
      logic [31:0]      data;
      int               arrive;
   } entry_t;

   entry_t          inflightQ[$];
   entry_t          fifoQ[$];
   logic [NREG-1:0] pendM;

   fmul_wb_tracker #(.TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .issue_valid(issue_valid),
      .issue_rd(issue_rd),
      .issue_ready(issue_ready),
      .fmul_result(fmul_result),
      .wb_valid(wb_valid),
      .wb_rd(wb_rd),
      .wb_data(wb_data),
      .wb_ready(wb_ready),
      .pending(pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-precision product of two small non-negative integers. The
   // product is built from the double encoding and is exact in this range.
   function automatic logic [31:0] fprod(input int a, input int b);
      int          p;
      logic [63:0] d;
      logic [10:0] e;
      p = a * b;
      if (p == 0) return 32'h0;
      d = $realtobits(real'(p));
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // fmul stand-in: operands are sampled at the issue edge, and the result
   // register updates two edges later.
   logic [31:0] fmulS1;
   logic [31:0] fmulS2;
   always @(posedge clk) begin
      fmulS1      <= fprod(opA, opB);
      fmulS2      <= fmulS1;
      fmul_result <= fmulS2;
   end

   // Counts one comparison and reports it if the DUT disagrees.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one cycle of inputs, checks outputs against the model, then
   // advances the model across the clock edge.
   task automatic applyStimulus(input logic iv, input logic [TAG_W-1:0] rd,
                                input int a, input int b,
                                input logic wr, input logic rst);
      logic            expValid;
      logic [TAG_W-1:0] expRd;
      logic [31:0]     expData;
      logic            expReady;
      logic            fire;
      logic            wbFire;
      @(negedge clk);
      issue_valid = iv;
      issue_rd    = rd;
      opA         = a;
      opB         = b;
      wb_ready    = wr;
      reset       = rst;
      #1;
      expValid = (fifoQ.size() != 0);
      expRd    = expValid ? fifoQ[0].rd   : '0;
      expData  = expValid ? fifoQ[0].data : '0;
      expReady = rst && ((fifoQ.size() + inflightQ.size()) < DEPTH) && !pendM[rd];
      checkOutput("wb_valid",    wb_valid,    expValid);
      checkOutput("wb_rd",       wb_rd,       expRd);
      checkOutput("wb_data",     wb_data,     expData);
      checkOutput("issue_ready", issue_ready, expReady);
      checkOutput("pending",     pending,     pendM);
      checkOutput("fifo_count",  dut.count_q, fifoQ.size());
      fire   = iv && expReady;
      wbFire = expValid && wr;
      @(posedge clk);
      edgeNum++;
      if (!rst) begin
         inflightQ.delete();
         fifoQ.delete();
         pendM = '0;
      end else begin
         if (wbFire) begin
            pendM[fifoQ[0].rd] = 1'b0;
            void'(fifoQ.pop_front());
         end
         while (inflightQ.size() > 0 && inflightQ[0].arrive == edgeNum) begin
            fifoQ.push_back(inflightQ.pop_front());
         end
         if (fire) begin
            inflightQ.push_back('{rd, fprod(a, b), edgeNum + LAT});
            pendM[rd] = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n, input logic wr);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 5'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), wr, 1'b1);
      end
   endtask

   // Main sequence: directed scenarios first, then a randomized soak.
   initial begin
      reset       = 1'b0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      wb_ready    = 1'b0;
      opA         = 0;
      opB         = 0;
      testCount   = 0;
      failCount   = 0;
      edgeNum     = 0;
      pendM       = '0;

      applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 1'b0);
      idle(2, 1'b0);

      // Single op: 2.0 x 3.0 into r7.
      applyStimulus(1'b1, 5'd7, 2, 3, 1'b0, 1'b1);
      idle(3, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("single_data",    wb_data, 32'h40C00000);
      checkOutput("single_rd",      wb_rd,   5'd7);
      checkOutput("single_pending", pending[7], 1'b1);
      idle(3, 1'b1);

      // Streaming issue to r1..r5.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 5'(i), i, i + 1, 1'b1, 1'b1);
      end
      idle(8, 1'b1);

      // Backpressure: only DEPTH ops are accepted.
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, 5'(i), i, 3, 1'b0, 1'b1);
      end
      idle(3, 1'b0);
      idle(8, 1'b1);

      // WAW hazard on r9 while r10 slips past.
      applyStimulus(1'b1, 5'd9, 4, 4, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd9, 5, 5, 1'b1, 1'b1);
      applyStimulus(1'b1, 5'd10, 6, 6, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'd9, 7, 7, 1'b1, 1'b1);
      idle(6, 1'b1);

      // Push and pop on the same edge with one entry queued. Operand 0 gives
      // a zero result, which must pass through unchanged.
      applyStimulus(1'b1, 5'd11, 3, 5, 1'b0, 1'b1);
      idle(1, 1'b0);
      applyStimulus(1'b1, 5'd12, 0, 9, 1'b0, 1'b1);
      idle(2, 1'b0);
      idle(4, 1'b1);

      // Reset with two ops queued and two in flight.
      applyStimulus(1'b1, 5'd1, 2, 2, 1'b0, 1'b1);
      applyStimulus(1'b1, 5'd2, 3, 3, 1'b0, 1'b1);
      idle(1, 1'b0);
      applyStimulus(1'b1, 5'd3, 4, 4, 1'b0, 1'b1);
      applyStimulus(1'b1, 5'd4, 5, 5, 1'b0, 1'b1);
      applyStimulus(1'b0, 5'd0, 0, 0, 1'b0, 1'b0);
      idle(6, 1'b1);

      // Randomized soak with a narrow tag range to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       ($urandom_range(0, 9) < 6), ($urandom_range(0, 59) != 0));
      end
      idle(10, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
